calc_op_initiator: RTL

- Issuing side of the calculator's level start/done handshake with its iterative arithmetic units (square root, multiply, divide).
- Accepts one operation request from the front-end, latches the operands and holds them stable for the whole operation.
- Raises the selected unit's `start`, captures its result when `done` rises, then drops `start` and waits for `done` to fall.
- Reports completion, timeout or an invalid opcode to the display/result path.

---
 rtl/calc_op_initiator_if.sv | 35 +++
 rtl/calc_op_initiator.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/calc_op_initiator_if.sv
// Bundle of the front-end request, unit handshake and result/status signals
// of the calculator's operation initiator.
interface calc_op_initiator_if #(
  parameter int DATA_W  = 16,
  parameter int N_UNITS = 3
);
  localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic                        req;
  logic [SEL_W-1:0]            op_sel;
  logic [DATA_W-1:0]           a_in;
  logic [DATA_W-1:0]           b_in;
  logic [N_UNITS-1:0]          unit_done;
  logic [N_UNITS*DATA_W-1:0]   unit_result;
  logic [N_UNITS-1:0]          unit_start;
  logic [DATA_W-1:0]           op_a;
  logic [DATA_W-1:0]           op_b;
  logic                        busy;
  logic [DATA_W-1:0]           result;
  logic                        result_valid;
  logic                        err_timeout;
  logic                        err_badop;

  modport master (
    input  req, op_sel, a_in, b_in, unit_done, unit_result,
    output unit_start, op_a, op_b, busy, result, result_valid,
           err_timeout, err_badop
  );

  modport slave (
    output req, op_sel, a_in, b_in, unit_done, unit_result,
    input  unit_start, op_a, op_b, busy, result, result_valid,
           err_timeout, err_badop
  );
endinterface

// File: rtl/calc_op_initiator.sv
// Issues one operation to an iterative arithmetic unit over a level
// start/done handshake and reports completion, timeout or a bad opcode.
module calc_op_initiator #(
  parameter int DATA_W      = 16,
  parameter int N_UNITS     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  calc_op_initiator_if.master   bus
);
  localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_RELEASE,
    S_REPORT,
    S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_badop_q, err_badop_d;

  logic              sel_done;
  logic [DATA_W-1:0] sel_result;
  logic              op_ok;
  logic              cnt_expired;
  logic [CNT_W-1:0]  cnt_next;

  assign op_ok       = int'(bus.op_sel) < N_UNITS;
  assign cnt_expired = (cnt_q == CNT_LAST);
  // Saturate so a done landing on the last count still leaves RELEASE expired.
  assign cnt_next    = cnt_expired ? cnt_q : cnt_q + 1'b1;

  // Only the selected unit's done/result are ever observed.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_done   = bus.unit_done[i];
        sel_result = bus.unit_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    err_badop_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (op_ok) begin
            sel_d   = bus.op_sel;
            op_a_d  = bus.a_in;
            op_b_d  = bus.b_in;
            state_d = S_LOAD;
          end else begin
            err_badop_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_next;
        if (sel_done) begin
          result_d = sel_result;
          state_d  = S_RELEASE;
        end else if (cnt_expired) begin
          state_d = S_ABORT;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_next;
        if (!sel_done) begin
          state_d = S_REPORT;
        end else if (cnt_expired) begin
          state_d = S_ABORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      err_badop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      err_badop_q <= err_badop_d;
    end
  end

  // Start decodes straight from the state so an async reset drops it at once.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      bus.unit_start[i] = (state_q == S_WAIT_DONE) && (sel_q == SEL_W'(i));
    end
  end

  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == S_REPORT);
  assign bus.err_timeout  = (state_q == S_ABORT);
  assign bus.err_badop    = err_badop_q;
endmodule
